// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives the column decoder, synchronizes the rows,
// classifies each full scan and debounces presses/releases at scan granularity.
module keypad_scanner #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       int_osc,
    input  logic       rst,
    input  logic [3:0] kb_row,
    output logic [1:0] kb_col,
    output logic       kb_en,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int            SW          = $clog2(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [3:0]    DEB_N       = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_CONFIRM,
        S_HELD,
        S_RELEASE_CONFIRM
    } state_t;

    // scan engine
    logic [3:0]    r_sync1, r_sync2;
    logic [SW-1:0] r_settle;
    logic [1:0]    r_col;
    logic          r_en;
    logic [1:0]    r_acc_cnt;     // 0 none, 1 single, 2 multi
    logic [3:0]    r_acc_code;
    logic          r_res_valid;
    logic [1:0]    r_res_cnt;
    logic [3:0]    r_res_code;

    logic [3:0]    w_act;
    logic [2:0]    w_col_cnt;
    logic [1:0]    w_col_row;
    logic [2:0]    w_sum;
    logic [1:0]    w_new_cnt;
    logic [3:0]    w_new_code;

    // debounce FSM
    state_t        r_state, w_state_n;
    logic [3:0]    r_cnt, w_cnt_n, w_cnt_inc;
    logic [3:0]    r_cand, w_cand_n;
    logic [3:0]    r_key_code, w_code_n;
    logic          r_key_valid, w_valid_n;
    logic          r_key_held, w_held_n;
    logic          w_none, w_single;

    assign w_act = ~r_sync2;

    always_comb begin
        w_col_cnt = '0;
        w_col_row = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (w_act[i]) begin
                w_col_cnt = w_col_cnt + 3'd1;
                w_col_row = 2'(i);
            end
        end
        // Saturating count of active keys so far; the code is only meaningful at count 1.
        w_sum      = {1'b0, r_acc_cnt} + w_col_cnt;
        w_new_cnt  = (w_sum > 3'd1) ? 2'd2 : w_sum[1:0];
        w_new_code = (r_acc_cnt == 2'd0) ? {r_col, w_col_row} : r_acc_code;
    end

    always_ff @(posedge int_osc) begin
        if (rst) begin
            r_sync1     <= '1;   // cleared to "no row active"
            r_sync2     <= '1;
            r_settle    <= '0;
            r_col       <= '0;
            r_en        <= 1'b0;
            r_acc_cnt   <= '0;
            r_acc_code  <= '0;
            r_res_valid <= 1'b0;
            r_res_cnt   <= '0;
            r_res_code  <= '0;
        end else begin
            r_en        <= 1'b1;
            r_sync1     <= kb_row;
            r_sync2     <= r_sync1;
            r_res_valid <= 1'b0;
            if (r_settle == SETTLE_LAST) begin
                r_settle <= '0;
                r_col    <= r_col + 2'd1;
                if (r_col == 2'd3) begin
                    r_res_valid <= 1'b1;
                    r_res_cnt   <= w_new_cnt;
                    r_res_code  <= w_new_code;
                    r_acc_cnt   <= '0;
                    r_acc_code  <= '0;
                end else begin
                    r_acc_cnt  <= w_new_cnt;
                    r_acc_code <= w_new_code;
                end
            end else begin
                r_settle <= r_settle + 1'b1;
            end
        end
    end

    assign w_none    = (r_res_cnt == 2'd0);
    assign w_single  = (r_res_cnt == 2'd1);
    assign w_cnt_inc = r_cnt + 4'd1;

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_cand_n  = r_cand;
        w_code_n  = r_key_code;
        w_valid_n = 1'b0;
        w_held_n  = r_key_held;
        if (r_res_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (w_single) begin
                        w_cand_n = r_res_code;
                        w_cnt_n  = 4'd1;
                        if (DEB_N == 4'd1) begin
                            w_state_n = S_HELD;
                            w_code_n  = r_res_code;
                            w_valid_n = 1'b1;
                            w_held_n  = 1'b1;
                        end else begin
                            w_state_n = S_PRESS_CONFIRM;
                        end
                    end
                end
                S_PRESS_CONFIRM: begin
                    if (!w_single) begin
                        w_state_n = S_IDLE;
                    end else if (r_res_code == r_cand) begin
                        w_cnt_n = w_cnt_inc;
                        if (w_cnt_inc == DEB_N) begin
                            w_state_n = S_HELD;
                            w_code_n  = r_cand;
                            w_valid_n = 1'b1;
                            w_held_n  = 1'b1;
                        end
                    end else begin
                        w_cand_n = r_res_code;
                        w_cnt_n  = 4'd1;
                    end
                end
                S_HELD: begin
                    if (w_none) begin
                        w_cnt_n = 4'd1;
                        if (DEB_N == 4'd1) begin
                            w_state_n = S_IDLE;
                            w_held_n  = 1'b0;
                        end else begin
                            w_state_n = S_RELEASE_CONFIRM;
                        end
                    end
                end
                S_RELEASE_CONFIRM: begin
                    if (w_none) begin
                        w_cnt_n = w_cnt_inc;
                        if (w_cnt_inc == DEB_N) begin
                            w_state_n = S_IDLE;
                            w_held_n  = 1'b0;
                        end
                    end else begin
                        w_state_n = S_HELD;
                    end
                end
                default: w_state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge int_osc) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cand      <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_cand      <= w_cand_n;
            r_key_code  <= w_code_n;
            r_key_valid <= w_valid_n;
            r_key_held  <= w_held_n;
        end
    end

    assign kb_col    = r_col;
    assign kb_en     = r_en;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans the calculator's 4x4 matrix keypad and produces one debounced key event per physical press. Consumed by the operand/operator entry logic that builds num1, num2 and op.
- Drives the external 2-to-4 column decoder through kb_en and a 2-bit column number, which map to board pins gpio_2, gpio_46 and gpio_47.
- Reads the four row lines, which are active-low with pull-ups.
- Runs on the SB_LFOSC clock, int_osc, at about 10 kHz.

Parameters:
- SETTLE_CYCLES, default 4: clocks each column is held driven. Rows are sampled on the last of these clocks. Legal values are 4 and above.
- DEBOUNCE_SCANS, default 3: number of consecutive identical full-scan results needed to accept a press or a release. Legal values are 1 to 15.

Ports:
- int_osc, input, 1: clock. All logic runs on the rising edge.
- rst, input, 1: reset, synchronous, active-high.
- kb_row, input, 4: row lines, active-low, asynchronous to the block.
- kb_col, output, 2: column number presented to the external decoder.
- kb_en, output, 1: decoder enable.
- key_code, output, 4: code of the accepted key, {col[1:0], row[1:0]}.
- key_valid, output, 1: one-cycle pulse when a new press is accepted.
- key_held, output, 1: high while the accepted key is considered pressed.

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-high.
  - While rst is high: kb_col=0, kb_en=0, key_code=0, key_valid=0, key_held=0.
  - All counters, the synchronizer and the candidate register clear, and the FSM goes to IDLE.
  - kb_en rises on the first clock after rst falls and stays high.
- Synchronizer:
  - kb_row passes through a 2-flop synchronizer before any use.
  - SETTLE_CYCLES>=4 guarantees the sampled value belongs to the current column.
- Scan engine:
  - A settle counter runs 0..SETTLE_CYCLES-1.
  - On the count SETTLE_CYCLES-1, the synchronized rows are sampled for the current kb_col, and kb_col increments, wrapping 3 to 0.
  - A full scan takes 4*SETTLE_CYCLES clocks.
  - Per-scan accumulation:
    - Zero active rows across all four columns gives the result NONE.
    - Exactly one active row in exactly one column gives SINGLE(code = {col,row}).
    - Anything else gives MULTI, treated as ghosting.
  - The result is evaluated on the clock that samples column 3. The FSM acts on it on the following clock.
  - The accumulator then clears for the next scan.
- Debounce FSM, one step per scan result; cnt is a 4-bit counter:
  - IDLE:
    - SINGLE(k) sets cand=k and cnt=1, then goes to PRESS_CONFIRM.
    - NONE or MULTI stays in IDLE.
  - PRESS_CONFIRM:
    - SINGLE(cand) increments cnt.
    - SINGLE(j) with j≠cand sets cand=j and cnt=1.
    - NONE or MULTI returns to IDLE.
  - Press acceptance:
    - When cnt reaches DEBOUNCE_SCANS (immediately, if DEBOUNCE_SCANS=1), the FSM goes to HELD.
    - On that same clock key_code<=cand and key_held<=1.
    - key_valid is high for exactly that one clock.
  - HELD:
    - NONE sets cnt=1 and goes to RELEASE_CONFIRM. If DEBOUNCE_SCANS=1 it goes straight to IDLE with key_held<=0.
    - SINGLE of any key, or MULTI, stays in HELD. There is no auto-repeat, and a second key is not reported before release.
  - RELEASE_CONFIRM:
    - NONE increments cnt. At DEBOUNCE_SCANS the FSM goes to IDLE and key_held<=0.
    - Any key returns to HELD without a key_valid pulse.
- Outputs:
  - key_code holds its last accepted value until the next acceptance.
  - key_valid is never high for two consecutive clocks.
- rst asserted mid-scan or mid-confirm:
  - Aborts immediately and produces no pulse.
  - The scan restarts at column 0 with a fresh settle count.

Test Plan (SETTLE_CYCLES=4, DEBOUNCE_SCANS=3, 16-clock scan):
1. Reset: rst high for 3 clocks, then low.
   - During reset, all outputs are 0.
   - kb_en=1 one clock after release.
   - kb_col steps 0,1,2,3,0 every 4 clocks.
2. Clean press: kb_row=4'b1101 whenever kb_col==2, held indefinitely.
   - Exactly one key_valid pulse, with key_code=4'h9, on the clock after the third qualifying scan ends.
   - key_held=1 from that clock.
   - No further pulses.
3. Bounce: the key from test 2 is present for 2 scans, absent for 1, then present for 3.
   - No pulse during the first two scans.
   - A single pulse after the last of the final 3 scans.
4. Ghosting: kb_row=4'b1110 at col 0 and 4'b1011 at col 3 simultaneously for 5 scans.
   - No key_valid.
   - key_held stays 0.
5. Release and glitch: hold key 4'h9 until accepted, then 2 empty scans, then 1 scan with the key, then 3 empty scans.
   - key_held stays 1 through the glitch.
   - key_held drops 1 clock after the third empty scan.
   - No extra key_valid.
6. Reset mid-confirm: 2 qualifying scans of key 4'h4 (col 1, row 0), then rst for 1 clock, then the key held.
   - No pulse before reset.
   - After reset the pulse arrives only after 3 new full scans, with key_code=4'h4.
